// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: valid/ready handshake, load-use bubble, flush.
// Optional ID_EX_STATS_EN adds bubble_cnt_o / flush_cnt_o counters.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush_i                  kill held and incoming instruction
//   in_valid_i / in_ready_o  decode-side handshake
//   pc_i ctrl_i imm_i        decoded payload
//   rs1/rs2/rd_addr_i        register addresses
//   rs1/rs2_data_i           register-file read data
//   out_valid_o/out_ready_i  EX-side handshake
//   *_o payload              registered copy of the inputs
//   hazard_o                 load-use stall this cycle
//   bubble_cnt_o flush_cnt_o (ID_EX_STATS_EN only) saturating counters
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [RA_W-1:0]   rs1_addr_i,
  input  logic [RA_W-1:0]   rs2_addr_i,
  input  logic [RA_W-1:0]   rd_addr_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [RA_W-1:0]   rs1_addr_o,
  output logic [RA_W-1:0]   rs2_addr_o,
  output logic [RA_W-1:0]   rd_addr_o,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic              hazard_o
`ifdef ID_EX_STATS_EN
  ,
  output logic [31:0]       bubble_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  // control word: {rmem, wmem, wen, ...} from the MSB down
  localparam int RMEM_BIT = CTRL_W - 1;
  localparam int WEN_BIT  = CTRL_W - 3;

  logic adv;
  logic held_load;
  logic rd_match;

  assign adv = !out_valid_o || out_ready_i;

  assign held_load = out_valid_o
                  && ctrl_o[RMEM_BIT]
                  && ctrl_o[WEN_BIT]
                  && (rd_addr_o != '0);

  assign rd_match = (rd_addr_o == rs1_addr_i)
                 || (rd_addr_o == rs2_addr_i);

  assign hazard_o = held_load && in_valid_i && rd_match;

  // a flush swallows the incoming instruction, so it is always ready
  assign in_ready_o = rst || flush_i || (adv && !hazard_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      pc_o        <= '0;
      ctrl_o      <= '0;
      imm_o       <= '0;
      rs1_addr_o  <= '0;
      rs2_addr_o  <= '0;
      rd_addr_o   <= '0;
      rs1_data_o  <= '0;
      rs2_data_o  <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (hazard_o) begin
      // held load drains to EX; dependent stays upstream
      if (adv) out_valid_o <= 1'b0;
    end else if (adv) begin
      out_valid_o <= in_valid_i;
      if (in_valid_i) begin
        pc_o       <= pc_i;
        ctrl_o     <= ctrl_i;
        imm_o      <= imm_i;
        rs1_addr_o <= rs1_addr_i;
        rs2_addr_o <= rs2_addr_i;
        rd_addr_o  <= rd_addr_i;
        rs1_data_o <= rs1_data_i;
        rs2_data_o <= rs2_data_i;
      end
    end
  end

`ifdef ID_EX_STATS_EN
  logic bubble_ev;
  logic flush_ev;

  assign bubble_ev = hazard_o && adv && !flush_i;
  assign flush_ev  = flush_i && (out_valid_o || in_valid_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (bubble_ev && (bubble_cnt_o != 32'hFFFF_FFFF))
        bubble_cnt_o <= bubble_cnt_o + 32'd1;
      if (flush_ev && (flush_cnt_o != 32'hFFFF_FFFF))
        flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table + in-order payload scoreboard.
// Hand sequences cover reset with a loaded payload and flush counting.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] pc_i;
  logic [23:0] ctrl_i;
  logic [31:0] imm_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] pc_o;
  logic [23:0] ctrl_o;
  logic [31:0] imm_o;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic        hazard_o;
`ifdef ID_EX_STATS_EN
  logic [31:0] bubble_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  id_ex_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .pc_i        (pc_i),
    .ctrl_i      (ctrl_i),
    .imm_i       (imm_i),
    .rs1_addr_i  (rs1_addr_i),
    .rs2_addr_i  (rs2_addr_i),
    .rd_addr_i   (rd_addr_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .pc_o        (pc_o),
    .ctrl_o      (ctrl_o),
    .imm_o       (imm_o),
    .rs1_addr_o  (rs1_addr_o),
    .rs2_addr_o  (rs2_addr_o),
    .rd_addr_o   (rd_addr_o),
    .rs1_data_o  (rs1_data_o),
    .rs2_data_o  (rs2_data_o),
    .hazard_o    (hazard_o)
`ifdef ID_EX_STATS_EN
    ,
    .bubble_cnt_o(bubble_cnt_o),
    .flush_cnt_o (flush_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rmem|wen set for loads, wen only for ALU ops
  localparam logic [23:0] LD_CTRL  = 24'hA0_0012;
  localparam logic [23:0] ALU_CTRL = 24'h20_0001;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic        ld;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ehz;
    logic        erdy;
    logic        eov;
    logic [31:0] epc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [23:0] ctrl;
    logic [31:0] imm;
    logic [14:0] addrs;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp;
  int   n_err;
  int   n_pop;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic iv, ordy, fl, ld,
                     input logic [31:0] pc,
                     input logic [4:0] rd, rs1, rs2,
                     input logic ehz, erdy, eov,
                     input logic [31:0] epc);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.ld = ld;
    v.pc = pc; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.ehz = ehz; v.erdy = erdy; v.eov = eov; v.epc = epc;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic iv, ordy, fl, ld,
                       input logic [31:0] pc,
                       input logic [4:0] rd, rs1, rs2);
    in_valid_i  = iv;
    out_ready_i = ordy;
    flush_i     = fl;
    pc_i        = pc;
    ctrl_i      = ld ? LD_CTRL : ALU_CTRL;
    imm_i       = pc ^ 32'hA5A5_0000;
    rd_addr_i   = rd;
    rs1_addr_i  = rs1;
    rs2_addr_i  = rs2;
    rs1_data_i  = pc + 32'h100;
    rs2_data_i  = ~pc;
  endtask

  // pop what EX takes, then push what decode hands over
  always @(negedge clk) begin
    if (rst || flush_i) begin
      sb.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        n_pop++;
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_pc", 64'(pc_o), 64'(e.pc));
          chk("sb_ctrl", 64'(ctrl_o), 64'(e.ctrl));
          chk("sb_imm", 64'(imm_o), 64'(e.imm));
          chk("sb_addrs",
              64'({rs1_addr_o, rs2_addr_o, rd_addr_o}),
              64'(e.addrs));
          chk("sb_data", {rs1_data_o, rs2_data_o},
              {e.d1, e.d2});
        end
      end
      if (in_valid_i && in_ready_o) begin
        exp_t e;
        e.pc    = pc_i;
        e.ctrl  = ctrl_i;
        e.imm   = imm_i;
        e.addrs = {rs1_addr_i, rs2_addr_i, rd_addr_i};
        e.d1    = rs1_data_i;
        e.d2    = rs2_data_i;
        sb.push_back(e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic reset_chk(input string tag);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEE0,
          5'd9, 5'd9, 5'd9);
    #1;
    chk({tag, "_rst_rdy"}, 64'(in_ready_o), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk({tag, "_rst_rdy2"}, 64'(in_ready_o), 64'd1);
    chk({tag, "_rst_ov"}, 64'(out_valid_o), 64'd0);
    chk({tag, "_rst_pc_imm"}, {pc_o, imm_o}, 64'd0);
    chk({tag, "_rst_ctrl"}, 64'(ctrl_o), 64'd0);
    chk({tag, "_rst_addr"},
        64'({rs1_addr_o, rs2_addr_o, rd_addr_o}), 64'd0);
    chk({tag, "_rst_data"}, {rs1_data_o, rs2_data_o}, 64'd0);
`ifdef ID_EX_STATS_EN
    chk({tag, "_rst_cnt"}, {bubble_cnt_o, flush_cnt_o}, 64'd0);
`endif
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_pop = 0;

    //  iv ordy fl ld  pc     rd  rs1 rs2  hz rdy ov  epc
    // streaming
    add(1, 1, 0, 0, 32'h00, 1, 0, 0, 0, 1, 1, 32'h00);
    add(1, 1, 0, 0, 32'h04, 2, 1, 0, 0, 1, 1, 32'h04);
    add(1, 1, 0, 0, 32'h08, 3, 2, 0, 0, 1, 1, 32'h08);
    add(1, 1, 0, 0, 32'h0C, 4, 3, 0, 0, 1, 1, 32'h0C);
    add(0, 1, 0, 0, 32'h00, 0, 0, 0, 0, 1, 0, 32'h0C);
    // LW x5 ; ADD x6,x5,x7
    add(1, 1, 0, 1, 32'h10, 5, 2, 0, 0, 1, 1, 32'h10);
    add(1, 1, 0, 0, 32'h14, 6, 5, 7, 1, 0, 0, 32'h10);
    add(1, 1, 0, 0, 32'h14, 6, 5, 7, 0, 1, 1, 32'h14);
    add(0, 1, 0, 0, 32'h00, 0, 0, 0, 0, 1, 0, 32'h14);
    // LW x0 ; ADD x1,x0,x0
    add(1, 1, 0, 1, 32'h20, 0, 2, 0, 0, 1, 1, 32'h20);
    add(1, 1, 0, 0, 32'h24, 1, 0, 0, 0, 1, 1, 32'h24);
    // backpressure 3 cycles
    add(1, 1, 0, 0, 32'h28, 7, 1, 2, 0, 1, 1, 32'h28);
    add(1, 0, 0, 0, 32'h2C, 8, 1, 2, 0, 0, 1, 32'h28);
    add(1, 0, 0, 0, 32'h2C, 8, 1, 2, 0, 0, 1, 32'h28);
    add(1, 0, 0, 0, 32'h2C, 8, 1, 2, 0, 0, 1, 32'h28);
    add(1, 1, 0, 0, 32'h2C, 8, 1, 2, 0, 1, 1, 32'h2C);
    add(0, 1, 0, 0, 32'h00, 0, 0, 0, 0, 1, 0, 32'h2C);
    // load-use while EX stalled
    add(1, 1, 0, 1, 32'h30, 3, 1, 0, 0, 1, 1, 32'h30);
    add(1, 0, 0, 0, 32'h34, 9, 1, 3, 1, 0, 1, 32'h30);
    add(1, 1, 0, 0, 32'h34, 9, 1, 3, 1, 0, 0, 32'h30);
    add(1, 1, 0, 0, 32'h34, 9, 1, 3, 0, 1, 1, 32'h34);
    add(0, 1, 0, 0, 32'h00, 0, 0, 0, 0, 1, 0, 32'h34);
    // flush with valid held and valid incoming
    add(1, 1, 0, 0, 32'h40, 1, 0, 0, 0, 1, 1, 32'h40);
    add(1, 0, 1, 0, 32'h44, 2, 0, 0, 0, 1, 0, 32'h40);
    add(0, 1, 1, 0, 32'h00, 0, 0, 0, 0, 1, 0, 32'h40);
    // flush beats a load-use hazard
    add(1, 1, 0, 1, 32'h50, 4, 1, 0, 0, 1, 1, 32'h50);
    add(1, 1, 1, 0, 32'h54, 6, 4, 0, 1, 1, 0, 32'h50);
    add(0, 1, 0, 0, 32'h00, 0, 0, 0, 0, 1, 0, 32'h50);

    reset_chk("init");

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      drive(v.iv, v.ordy, v.fl, v.ld, v.pc,
            v.rd, v.rs1, v.rs2);
      #1;
      chk($sformatf("v%0d_hazard", i),
          64'(hazard_o), 64'(v.ehz));
      chk($sformatf("v%0d_in_ready", i),
          64'(in_ready_o), 64'(v.erdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i),
          64'(out_valid_o), 64'(v.eov));
      chk($sformatf("v%0d_pc", i), 64'(pc_o), 64'(v.epc));
    end

    chk("pop_count", 64'(n_pop), 64'd12);
    chk("sb_empty", 64'(sb.size()), 64'd0);
`ifdef ID_EX_STATS_EN
    chk("bubble_cnt", 64'(bubble_cnt_o), 64'd2);
    chk("flush_cnt", 64'(flush_cnt_o), 64'd2);
`endif

    // hand flush: valid held + valid incoming, one count
    drive(1, 1, 0, 0, 32'h70, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("hf_ov_pre", 64'(out_valid_o), 64'd1);
    drive(1, 0, 1, 0, 32'h74, 2, 0, 0);
    #1;
    chk("hf_rdy", 64'(in_ready_o), 64'd1);
    @(posedge clk);
    #1;
    chk("hf_ov", 64'(out_valid_o), 64'd0);
    chk("hf_pc_hold", 64'(pc_o), 64'h70);
`ifdef ID_EX_STATS_EN
    chk("hf_flush_cnt", 64'(flush_cnt_o), 64'd3);
`endif

    // reload a payload, then reset mid-run
    drive(1, 0, 0, 0, 32'h80, 3, 1, 2);
    @(posedge clk);
    #1;
    chk("pre_rst_ov", 64'(out_valid_o), 64'd1);
    reset_chk("mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
